// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one Hack ALU among NREQ requesters.
// One operation in flight: IDLE (grant) -> EXEC (ALU settles) -> RESP (hand back).
module alu_share_arbiter #(
  parameter  int unsigned NREQ = 4,
  parameter  int unsigned W    = 16,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*W-1:0]   req_x,
  input  logic [NREQ*W-1:0]   req_y,
  input  logic [NREQ*6-1:0]   req_ctl,
  output logic [W-1:0]        alu_x,
  output logic [W-1:0]        alu_y,
  output logic [5:0]          alu_ctl,
  input  logic [W-1:0]        alu_out,
  input  logic                alu_zr,
  input  logic                alu_ng,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [IDW-1:0]      resp_id,
  output logic [W-1:0]        resp_out,
  output logic                resp_zr,
  output logic                resp_ng,
  output logic                busy
);

  localparam int unsigned CW = 6;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state;
  logic [W-1:0]    x_q;
  logic [W-1:0]    y_q;
  logic [CW-1:0]   ctl_q;
  logic [W-1:0]    res_q;
  logic            zr_q;
  logic            ng_q;
  logic [IDW-1:0]  id_q;
  logic [IDW-1:0]  last_grant;
  logic            resp_valid_q;
  logic            busy_q;

  logic [IDW-1:0]  winner;
  logic            found;
  int              idx;

  // Round-robin search: first valid requester after last_grant, wrapping.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      idx = (int'(last_grant) + k) % int'(NREQ);
      if (!found && req_valid[IDW'(idx)]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  // Grant is combinational in IDLE and forced low while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state == IDLE) && found) begin
      req_ready[winner] = 1'b1;
    end
  end

  // Sequencer: latch operands on grant, capture ALU result, hold until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      ctl_q        <= '0;
      res_q        <= '0;
      zr_q         <= 1'b0;
      ng_q         <= 1'b0;
      id_q         <= '0;
      last_grant   <= IDW'(NREQ - 1);
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            x_q        <= req_x[int'(winner)*W +: W];
            y_q        <= req_y[int'(winner)*W +: W];
            ctl_q      <= req_ctl[int'(winner)*CW +: CW];
            id_q       <= winner;
            last_grant <= winner;
            busy_q     <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          res_q        <= alu_out;
          zr_q         <= alu_zr;
          ng_q         <= alu_ng;
          resp_valid_q <= 1'b1;
          state        <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          resp_valid_q <= 1'b0;
          busy_q       <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

  assign alu_x      = x_q;
  assign alu_y      = y_q;
  assign alu_ctl    = ctl_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = id_q;
  assign resp_out   = res_q;
  assign resp_zr    = zr_q;
  assign resp_ng    = ng_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with a behavioural Hack ALU attached.
module tb_alu_share_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 16;
  localparam int unsigned IDW  = 2;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_x;
  logic [NREQ*W-1:0] req_y;
  logic [NREQ*6-1:0] req_ctl;
  logic [W-1:0]      alu_x;
  logic [W-1:0]      alu_y;
  logic [5:0]        alu_ctl;
  logic [W-1:0]      alu_out;
  logic              alu_zr;
  logic              alu_ng;
  logic              resp_valid;
  logic              resp_ready;
  logic [IDW-1:0]    resp_id;
  logic [W-1:0]      resp_out;
  logic              resp_zr;
  logic              resp_ng;
  logic              busy;

  alu_share_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_ctl(req_ctl),
    .alu_x(alu_x), .alu_y(alu_y), .alu_ctl(alu_ctl),
    .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_out(resp_out),
    .resp_zr(resp_zr), .resp_ng(resp_ng), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared Hack ALU: {zx,nx,zy,ny,f,no}
  logic [W-1:0] ax, ay, ao;
  always_comb begin
    ax = alu_ctl[5] ? '0 : alu_x;
    if (alu_ctl[4]) ax = ~ax;
    ay = alu_ctl[3] ? '0 : alu_y;
    if (alu_ctl[2]) ay = ~ay;
    ao = alu_ctl[1] ? (ax + ay) : (ax & ay);
    if (alu_ctl[0]) ao = ~ao;
    alu_out = ao;
    alu_zr  = (ao == '0);
    alu_ng  = ao[W-1];
  end

  typedef struct {
    logic [IDW-1:0] id;
    logic [W-1:0]   out;
    logic           zr;
    logic           ng;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int id, input logic [W-1:0] o, input logic zr, input logic ng);
    exp_t e;
    e.id = IDW'(id); e.out = o; e.zr = zr; e.ng = ng;
    sb.push_back(e);
  endtask

  task automatic drive(input int id, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [5:0] ctl);
    req_x[id*W +: W]   = x;
    req_y[id*W +: W]   = y;
    req_ctl[id*6 +: 6] = ctl;
    req_valid[id]      = 1'b1;
  endtask

  // Polls req_ready[id] at negedge+1 for a bounded number of cycles.
  task automatic wait_grant(input int id);
    bit got = 0;
    for (int n = 0; n < 40 && !got; n++) begin
      #1;
      if (req_ready[id]) got = 1;
      else @(negedge clk);
    end
    chk($sformatf("grant_wait_req%0d", id), 64'(got), 64'd1);
  endtask

  task automatic wait_idle();
    bit got = 0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (!busy) got = 1;
    end
    chk("idle_wait", 64'(got), 64'd1);
  endtask

  task automatic run_op(input int id, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [5:0] ctl, input logic [W-1:0] o,
                        input logic zr, input logic ng);
    push(id, o, zr, ng);
    @(negedge clk);
    drive(id, x, y, ctl);
    wait_grant(id);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    wait_idle();
  endtask

  // Monitor: every completed response handshake is matched against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && resp_valid && resp_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_resp: got id=%0d out=%0h with empty scoreboard", resp_id, resp_out);
        end else begin
          e = sb.pop_front();
          chk("resp_id",  64'(resp_id),  64'(e.id));
          chk("resp_out", 64'(resp_out), 64'(e.out));
          chk("resp_zr",  64'(resp_zr),  64'(e.zr));
          chk("resp_ng",  64'(resp_ng),  64'(e.ng));
        end
      end
    end
  end

  initial begin
    int last_cyc;
    bit got;
    int exp_id;
    rst_n      = 1'b0;
    req_valid  = 4'hF;
    req_x      = {$urandom, $urandom};
    req_y      = {$urandom, $urandom};
    req_ctl    = 24'($urandom);
    resp_ready = 1'b1;

    // Reset with active random requests
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_resp_valid",64'(resp_valid),64'd0);
    chk("rst_alu_x",     64'(alu_x),     64'd0);
    chk("rst_alu_y",     64'(alu_y),     64'd0);
    chk("rst_alu_ctl",   64'(alu_ctl),   64'd0);
    chk("rst_resp_id",   64'(resp_id),   64'd0);
    chk("rst_resp_out",  64'(resp_out),  64'd0);
    chk("rst_resp_flags",64'({resp_zr, resp_ng}), 64'd0);
    req_valid = '0;
    rst_n     = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("idle_busy",      64'(busy),       64'd0);
    chk("idle_resp_valid",64'(resp_valid), 64'd0);
    chk("idle_req_ready", 64'(req_ready),  64'd0);

    // Single AND on req0 with explicit latency checks
    push(0, 16'h00F0, 1'b0, 1'b0);
    @(negedge clk);
    drive(0, 16'h00F0, 16'h0FF0, 6'b000000);
    #1;
    chk("and_accept_ready", 64'(req_ready), 64'b0001);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("and_exec_alu_x",     64'(alu_x),      64'h00F0);
    chk("and_exec_busy",      64'(busy),       64'd1);
    chk("and_exec_resp_valid",64'(resp_valid), 64'd0);
    @(negedge clk);
    chk("and_resp_valid",     64'(resp_valid), 64'd1);
    wait_idle();

    // Flags: zero on req2, minus one on req3 (leaves last_grant=3)
    run_op(2, 16'h1234, 16'h5678, 6'b101010, 16'h0000, 1'b1, 1'b0);
    run_op(3, 16'h1234, 16'h5678, 6'b111010, 16'hFFFF, 1'b0, 1'b1);

    // Round robin with all requesters held valid
    push(0, 16'h0011, 1'b0, 1'b0);
    push(1, 16'h0022, 1'b0, 1'b0);
    push(2, 16'h8003, 1'b0, 1'b1);
    push(3, 16'h0000, 1'b1, 1'b0);
    push(0, 16'h0011, 1'b0, 1'b0);
    push(1, 16'h0022, 1'b0, 1'b0);
    @(negedge clk);
    drive(0, 16'h0001, 16'h0010, 6'b000010);
    drive(1, 16'h0002, 16'h0020, 6'b000010);
    drive(2, 16'h8000, 16'h0003, 6'b000010);
    drive(3, 16'hFFFF, 16'h0001, 6'b000010);
    last_cyc = 0;
    for (int g = 0; g < 6; g++) begin
      got = 0;
      for (int n = 0; n < 40 && !got; n++) begin
        #1;
        if (req_ready != '0) got = 1;
        else @(negedge clk);
      end
      chk("rr_grant_wait", 64'(got), 64'd1);
      exp_id = g % 4;
      chk($sformatf("rr_grant%0d", g), 64'(req_ready), 64'(4'b0001 << exp_id));
      if (g > 0) chk($sformatf("rr_interval%0d", g), 64'(cyc - last_cyc), 64'd3);
      last_cyc = cyc;
      @(posedge clk);
    end
    #1;
    req_valid = '0;
    wait_idle();

    // Backpressure in RESP with a competing request pending
    resp_ready = 1'b0;
    push(0, 16'h0034, 1'b0, 1'b0);
    @(negedge clk);
    drive(0, 16'h1234, 16'h00FF, 6'b000000);
    wait_grant(0);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    got = 0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (resp_valid) got = 1;
    end
    chk("bp_resp_wait", 64'(got), 64'd1);
    push(1, 16'h0002, 1'b0, 1'b0);
    drive(1, 16'h0005, 16'h0003, 6'b010011);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_resp_valid", 64'(resp_valid), 64'd1);
      chk("bp_resp_out",   64'(resp_out),   64'h0034);
      chk("bp_resp_id",    64'(resp_id),    64'd0);
      chk("bp_req_ready",  64'(req_ready),  64'd0);
      chk("bp_busy",       64'(busy),       64'd1);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_busy",  64'(busy),      64'd0);
    chk("bp_release_grant", 64'(req_ready), 64'b0010);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    wait_idle();

    // Async reset while in EXEC discards the transaction
    @(negedge clk);
    drive(0, 16'h0F0F, 16'h00FF, 6'b000010);
    wait_grant(0);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    #1;
    chk("ar_exec_busy", 64'(busy), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_busy_drop",  64'(busy),       64'd0);
    chk("ar_valid_drop", 64'(resp_valid), 64'd0);
    chk("ar_alu_x_drop", 64'(alu_x),      64'd0);
    @(posedge clk);
    @(negedge clk);
    push(1, 16'h0002, 1'b0, 1'b0);
    push(2, 16'h00FF, 1'b0, 1'b0);
    drive(1, 16'h0005, 16'h0003, 6'b010011);
    drive(2, 16'h00AA, 16'h0055, 6'b000010);
    rst_n = 1'b1;
    #1;
    chk("ar_first_grant", 64'(req_ready), 64'b0010);
    wait_grant(1);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    wait_grant(2);
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    wait_idle();

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
